// File: rtl/apb_uart_reg_slave.sv
// APB completer for the UART register block: TX/RX byte FIFOs, CTRL, BAUDDIV,
// sticky overrun flag, programmable wait states and PSLVERR on illegal accesses.
module apb_uart_reg_slave #(
  parameter int ADDRWIDTH   = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [31:0]          PWDATA,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_pop,
  input  logic [7:0]           rx_data,
  input  logic                 rx_push,
  output logic [15:0]          baud_div,
  output logic                 irq
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;  // extra MSB distinguishes full from empty
  localparam int IW = ADDRWIDTH - 2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [2:0]    wait_cnt_r, wait_cnt_nxt_s;
  logic          pready_s;

  logic [7:0]    tx_mem_r [FIFO_DEPTH];
  logic [7:0]    rx_mem_r [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
  logic [3:0]    ctrl_r;
  logic [15:0]   baud_r;
  logic          overrun_r;

  logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [IW-1:0] idx_s;
  logic          sel_data_s, sel_status_s, sel_ctrl_s, sel_baud_s, unmapped_s;
  logic          xfer_s, wr_s, rd_s;
  logic          tx_push_s, tx_pop_s, tx_err_s, rx_pop_s, rx_err_s;
  logic          rx_accept_s, rx_overrun_s, ovr_clr_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign unused_s = ^{PPROT, PWDATA[31:16], PSTRB[3:2], PADDR[1:0]};

  // FIFO status from pointer flops
  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full_s  = (tx_wp_r[PW-1] != tx_rp_r[PW-1]) && (tx_wp_r[PW-2:0] == tx_rp_r[PW-2:0]);
  assign rx_empty_s = (rx_wp_r == rx_rp_r);
  assign rx_full_s  = (rx_wp_r[PW-1] != rx_rp_r[PW-1]) && (rx_wp_r[PW-2:0] == rx_rp_r[PW-2:0]);

  // Address decode on word index
  assign idx_s        = PADDR[ADDRWIDTH-1:2];
  assign sel_data_s   = (idx_s == IW'(0));
  assign sel_status_s = (idx_s == IW'(1));
  assign sel_ctrl_s   = (idx_s == IW'(2));
  assign sel_baud_s   = (idx_s == IW'(3));
  assign unmapped_s   = !(sel_data_s || sel_status_s || sel_ctrl_s || sel_baud_s);

  // Side effects happen only in the completion cycle
  assign xfer_s = PSEL && PENABLE && pready_s;
  assign wr_s   = xfer_s && PWRITE;
  assign rd_s   = xfer_s && !PWRITE;

  assign tx_push_s    = wr_s && sel_data_s && PSTRB[0] && !tx_full_s;
  assign tx_err_s     = wr_s && sel_data_s && PSTRB[0] && tx_full_s;
  assign tx_pop_s     = tx_pop && tx_valid;
  assign rx_pop_s     = rd_s && sel_data_s && !rx_empty_s;
  assign rx_err_s     = rd_s && sel_data_s && rx_empty_s;
  assign rx_accept_s  = rx_push && ctrl_r[1] && (!rx_full_s || rx_pop_s);
  assign rx_overrun_s = rx_push && ctrl_r[1] && rx_full_s && !rx_pop_s;
  assign ovr_clr_s    = wr_s && sel_status_s && PSTRB[0] && PWDATA[4];

  assign PREADY   = pready_s;
  assign PSLVERR  = xfer_s && (unmapped_s || tx_err_s || rx_err_s);
  assign PRDATA   = rdata_s;
  assign tx_valid = ctrl_r[0] && !tx_empty_s;
  assign tx_data  = tx_mem_r[tx_rp_r[PW-2:0]];
  assign baud_div = baud_r;
  assign irq      = (ctrl_r[2] && !tx_full_s) || (ctrl_r[3] && !rx_empty_s) || overrun_r;

  // Next-state and PREADY for the setup/access handshake
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    pready_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt_s    = ST_ACCESS;
          wait_cnt_nxt_s = 3'(WAIT_STATES);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (PSEL && PENABLE) begin
          if (wait_cnt_r == 3'd0) begin
            pready_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r - 3'd1;
          end
        end else if (!PSEL) begin
          state_nxt_s = ST_IDLE;
        end else begin
          // a fresh setup phase restarts the wait count
          wait_cnt_nxt_s = 3'(WAIT_STATES);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Read data mux, zero outside a read completion
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (rd_s) begin
      case (1'b1)
        sel_data_s:   rdata_s = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_mem_r[rx_rp_r[PW-2:0]]};
        sel_status_s: rdata_s = {27'h000_0000, overrun_r, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
        sel_ctrl_s:   rdata_s = {28'h000_0000, ctrl_r};
        sel_baud_s:   rdata_s = {16'h0000, baud_r};
        default:      rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Handshake state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // TX FIFO: APB pushes, serial engine pops
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_wp_r <= '0;
      tx_rp_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_r[i] <= 8'h00;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wp_r[PW-2:0]] <= PWDATA[7:0];
        tx_wp_r <= tx_wp_r + PW'(1);
      end
      if (tx_pop_s) begin
        tx_rp_r <= tx_rp_r + PW'(1);
      end
    end
  end

  // RX FIFO: serial engine pushes, APB DATA reads pop
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_wp_r <= '0;
      rx_rp_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_r[i] <= 8'h00;
    end else begin
      if (rx_accept_s) begin
        rx_mem_r[rx_wp_r[PW-2:0]] <= rx_data;
        rx_wp_r <= rx_wp_r + PW'(1);
      end
      if (rx_pop_s) begin
        rx_rp_r <= rx_rp_r + PW'(1);
      end
    end
  end

  // CTRL, BAUDDIV and sticky overrun (set wins over a same-cycle clear)
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_r    <= 4'h0;
      baud_r    <= 16'h0010;
      overrun_r <= 1'b0;
    end else begin
      if (wr_s && sel_ctrl_s && PSTRB[0]) ctrl_r <= PWDATA[3:0];
      if (wr_s && sel_baud_s && PSTRB[0]) baud_r[7:0]  <= PWDATA[7:0];
      if (wr_s && sel_baud_s && PSTRB[1]) baud_r[15:8] <= PWDATA[15:8];
      if (rx_overrun_s) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

endmodule
